// File: rtl/aidc_lite_decomp_ctrl.sv
// ============================================================================
// Module      : aidc_lite_decomp_ctrl
// Description : Job controller for a block decompression engine; issues 64B
//               read-block requests, tracks engine output and write commits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aidc_lite_decomp_ctrl #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [31:0] src_addr_i,
    input  logic [31:0] dst_addr_i,
    input  logic [25:0] len_i,
    output logic        done_o,
    output logic        busy_o,
    output logic        rd_valid_o,
    input  logic        rd_ready_i,
    output logic [31:0] rd_addr_o,
    input  logic        blk_out_i,
    output logic        wr_valid_o,
    input  logic        wr_ready_i,
    output logic [31:0] wr_addr_o,
    input  logic        wr_ack_i
);

    localparam logic [25:0] C_MAX_OUT = 26'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_src;
    logic [31:0] r_dst;
    logic [25:0] r_len;
    logic [25:0] r_rd_issued;
    logic [25:0] r_rd_outstanding;
    logic [25:0] r_wr_pend;
    logic [25:0] r_wr_issued;
    logic [25:0] r_wr_acked;

    logic w_busy;
    logic w_start;
    logic w_rd_hs;
    logic w_wr_hs;
    logic w_blk;
    logic w_ack;

    assign w_busy  = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_start = start_i && !w_busy;

    assign rd_valid_o = (r_state == ST_RUN) && (r_rd_issued < r_len)
                        && (r_rd_outstanding < C_MAX_OUT);
    assign rd_addr_o  = r_src + {r_rd_issued, 6'b0};
    assign wr_valid_o = w_busy && (r_wr_pend != 26'd0);
    assign wr_addr_o  = r_dst + {r_wr_issued, 6'b0};
    assign done_o     = (r_state == ST_DONE);
    assign busy_o     = w_busy;

    assign w_rd_hs = rd_valid_o && rd_ready_i;
    assign w_wr_hs = wr_valid_o && wr_ready_i;
    // Stray engine/memory pulses are dropped so the counters never wrap.
    assign w_blk   = blk_out_i && w_busy && (r_rd_outstanding != 26'd0);
    assign w_ack   = wr_ack_i && w_busy && (r_wr_acked != r_wr_issued);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    w_state_nxt = (len_i == 26'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_rd_issued == r_len) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_wr_acked == r_len) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_src            <= 32'd0;
            r_dst            <= 32'd0;
            r_len            <= 26'd0;
            r_rd_issued      <= 26'd0;
            r_rd_outstanding <= 26'd0;
            r_wr_pend        <= 26'd0;
            r_wr_issued      <= 26'd0;
            r_wr_acked       <= 26'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_src            <= src_addr_i;
                r_dst            <= dst_addr_i;
                r_len            <= len_i;
                r_rd_issued      <= 26'd0;
                r_rd_outstanding <= 26'd0;
                r_wr_pend        <= 26'd0;
                r_wr_issued      <= 26'd0;
                r_wr_acked       <= 26'd0;
            end else begin
                r_rd_issued <= r_rd_issued + 26'(w_rd_hs);
                r_wr_issued <= r_wr_issued + 26'(w_wr_hs);
                r_wr_acked  <= r_wr_acked + 26'(w_ack);
                case ({w_rd_hs, w_blk})
                    2'b10:   r_rd_outstanding <= r_rd_outstanding + 26'd1;
                    2'b01:   r_rd_outstanding <= r_rd_outstanding - 26'd1;
                    default: r_rd_outstanding <= r_rd_outstanding;
                endcase
                case ({w_blk, w_wr_hs})
                    2'b10:   r_wr_pend <= r_wr_pend + 26'd1;
                    2'b01:   r_wr_pend <= r_wr_pend - 26'd1;
                    default: r_wr_pend <= r_wr_pend;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/aidc_lite_decomp_ctrl.md
AIDC_LITE_DECOMP_CTRL -- requirements
Module: aidc_lite_decomp_ctrl

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, max read blocks issued but not yet returned by the engine (1..15).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start_i  input  1  single-cycle job start pulse from config block.
REQ-005 SHALL have port src_addr_i  input  32  compressed source base byte address.
REQ-006 SHALL have port dst_addr_i  input  32  decompressed destination base byte address.
REQ-007 SHALL have port len_i  input  26 ([31:6])  job length in 64-byte blocks.
REQ-008 SHALL have port done_o  input-to-config level  1  output, job complete.
REQ-009 SHALL have port busy_o  output  1  job in progress.
REQ-010 SHALL have ports rd_valid_o output 1, rd_ready_i input 1, rd_addr_o output 32: read-block request, one 64B block per handshake.
REQ-011 SHALL have port blk_out_i  input  1  engine pulse, one output block produced (one per read block).
REQ-012 SHALL have ports wr_valid_o output 1, wr_ready_i input 1, wr_addr_o output 32: write-block request.
REQ-013 SHALL have port wr_ack_i  input  1  pulse, one write block committed to memory.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-015 IDLE->RUN on start_i with len_i!=0; IDLE->DONE on start_i with len_i==0 (done_o next cycle).
REQ-016 On start SHALL latch src/dst/len and clear counters rd_issued, rd_outstanding, wr_pend, wr_issued, wr_acked (all 26-bit).
REQ-017 rd_valid_o SHALL be 1 in RUN iff rd_issued<len and rd_outstanding<MAX_OUTSTANDING; rd_addr_o = src + rd_issued*64, modulo 2^32.
REQ-018 rd_valid_o/rd_addr_o SHALL stay stable until rd_ready_i is sampled high.
REQ-019 Read handshake SHALL increment rd_issued and rd_outstanding; blk_out_i SHALL decrement rd_outstanding and increment wr_pend; simultaneous events leave the affected counter unchanged.
REQ-020 wr_valid_o SHALL be 1 iff wr_pend>0 in RUN/DRAIN; wr_addr_o = dst + wr_issued*64 mod 2^32, stable until accepted.
REQ-021 Write handshake SHALL decrement wr_pend, increment wr_issued; simultaneous blk_out_i and write handshake leave wr_pend unchanged.
REQ-022 RUN->DRAIN when rd_issued==len; DRAIN->DONE when wr_acked==len.
REQ-023 DONE SHALL hold done_o=1 until next start_i, which re-enters RUN/DONE per REQ-015 and clears done_o the same edge.
REQ-024 busy_o SHALL be 1 in RUN and DRAIN only; start_i while busy SHALL be ignored.
REQ-025 blk_out_i with rd_outstanding==0, or wr_ack_i with wr_acked==wr_issued, SHALL be ignored (no underflow/overflow).
REQ-026 blk_out_i and wr_ack_i SHALL be ignored in IDLE and DONE.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, all counters and latched registers 0, done_o=0, busy_o=0, rd_valid_o=0, wr_valid_o=0, addresses 0.
REQ-028 Reset mid-job SHALL abort; no request asserted until next start after rst_n deasserts.

Verification
REQ-029 start, src=0x1000, dst=0x8000, len=3, ready always 1, engine returns 2 cycles after read -> rd_addr 0x1000/0x1040/0x1080, wr_addr 0x8000/0x8040/0x8080, done_o after 3rd wr_ack.
REQ-030 len=8, MAX_OUTSTANDING=4, blk_out_i withheld -> exactly 4 reads issued, rd_valid_o low until first blk_out_i.
REQ-031 src=0xFFFFFFC0, len=2 -> rd_addr 0xFFFFFFC0 then 0x00000000.
REQ-032 len=0 start -> done_o=1 next cycle, no rd_valid_o/wr_valid_o ever.
REQ-033 rd_ready_i held low 5 cycles -> rd_addr_o stable; second start_i during RUN ignored; rst_n low mid-DRAIN -> outputs 0 immediately, done_o stays 0.
